// File: rtl/lsu_dram_ctrl.sv
// Memory-stage load/store controller in front of a word-wide RAM.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word requests instead of force-aligning them.
module lsu_dram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  state_t              state, state_nx;
  logic                accept, req_err;
  logic [1:0]          req_lane;
  logic [ADDR_W-1:0]   req_word;

  logic                lat_we, lat_uns;
  logic [1:0]          lat_size, lat_lane;
  logic [DATA_W-1:0]   lat_wdata;

  logic                rd_en_nx, wr_en_nx, resp_valid_nx, resp_err_nx;
  logic [ADDR_W-1:0]   rd_addr_nx, wr_addr_nx;
  logic [DATA_W-1:0]   wr_data_nx, resp_rdata_nx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_word  = req_addr[ADDR_W+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
  assign req_err = (req_size == 2'd3);
`endif

  // Half and word lanes are force-aligned; with trapping enabled misaligned ones never reach the RAM.
  always_comb begin
    req_lane = 2'b00;
    case (req_size)
      2'd0:    req_lane = req_addr[1:0];
      2'd1:    req_lane = {req_addr[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
  end

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [1:0] size,
                                                input logic [1:0] lane,
                                                input logic uns);
    logic [DATA_W-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'd0:    extract = {{(DATA_W-8){~uns & sh[7]}}, sh[7:0]};
      2'd1:    extract = {{(DATA_W-16){~uns & sh[15]}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] word,
                                              input logic [DATA_W-1:0] wdata,
                                              input logic [1:0] size,
                                              input logic [1:0] lane);
    logic [DATA_W-1:0] mask;
    logic [4:0]        sh;
    sh    = {lane, 3'b000};
    mask  = (size == 2'd0) ? {{(DATA_W-8){1'b0}}, 8'hFF} : {{(DATA_W-16){1'b0}}, 16'hFFFF};
    merge = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  always_comb begin
    state_nx      = state;
    rd_en_nx      = 1'b0;
    wr_en_nx      = 1'b0;
    resp_valid_nx = 1'b0;
    resp_err_nx   = 1'b0;
    resp_rdata_nx = '0;
    rd_addr_nx    = rd_addr;
    wr_addr_nx    = wr_addr;
    wr_data_nx    = wr_data;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_nx = 1'b1;
            resp_err_nx   = 1'b1;
          end else if (req_we && req_size == 2'd2) begin
            state_nx      = WR;
            wr_en_nx      = 1'b1;
            wr_addr_nx    = req_word;
            wr_data_nx    = req_wdata;
            resp_valid_nx = 1'b1;
          end else begin
            state_nx   = RD;
            rd_en_nx   = 1'b1;
            rd_addr_nx = req_word;
          end
        end
      end
      RD: state_nx = WAIT;
      // rd_data is valid here: either finish the load or issue the merged write.
      WAIT: begin
        resp_valid_nx = 1'b1;
        if (lat_we) begin
          state_nx   = WR;
          wr_en_nx   = 1'b1;
          wr_addr_nx = rd_addr;
          wr_data_nx = merge(rd_data, lat_wdata, lat_size, lat_lane);
        end else begin
          state_nx      = IDLE;
          resp_rdata_nx = extract(rd_data, lat_size, lat_lane, lat_uns);
        end
      end
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nx;
      rd_en      <= rd_en_nx;
      wr_en      <= wr_en_nx;
      resp_valid <= resp_valid_nx;
      resp_err   <= resp_err_nx;
      resp_rdata <= resp_rdata_nx;
      rd_addr    <= rd_addr_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= 2'd0;
      lat_lane  <= 2'd0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_uns   <= req_unsigned;
      lat_size  <= req_size;
      lat_lane  <= req_lane;
      lat_wdata <= req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_dram_ctrl.sv
// Self-checking bench for lsu_dram_ctrl: directed table, multi-cycle sequences and random
// traffic compared against a byte-level memory model (honours LSU_MISALIGN_TRAP_EN).
module tb_lsu_dram_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_bad = 0;

  logic        e_err, e_rd, e_wr;
  int          e_win, e_rdy_low;
  logic [31:0] e_rdata, e_wdata;
  logic [11:0] e_waddr;

  int          g_resp, g_rd, g_wr, g_rdy_low, g_win;
  logic [31:0] g_rdata, g_wdata;
  logic        g_err;
  logic [11:0] g_waddr, g_raddr;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t tbl [15];

  lsu_dram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // RAM with a registered read port and a negedge write port.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];
  always @(negedge clk) if (wr_en) ram[wr_addr] <= wr_data;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: byte-wise lane handling on a shadow memory, timing from the protocol rules.
  task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                         input logic [13:0] addr, input logic [31:0] wdata);
    int          wa, lane, nb;
    logic [31:0] word, res;
    bit          err;
    longint      v;
    wa   = int'(addr[13:2]);
    lane = int'(addr[1:0]);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err  = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!err && (lane % nb) != 0) err = 1'b1;
`else
    if (!err) lane = lane - (lane % nb);
`endif
    word      = shadow[wa];
    e_err     = err;
    e_rdata   = 32'h0;
    e_rd      = 1'b0;
    e_wr      = 1'b0;
    e_win     = 0;
    e_rdy_low = 0;
    e_waddr   = addr[13:2];
    e_wdata   = 32'h0;
    if (!err) begin
      if (we) begin
        res = word;
        for (int b = 0; b < nb; b++) res[8*(lane+b) +: 8] = wdata[8*b +: 8];
        e_wr       = 1'b1;
        e_wdata    = res;
        shadow[wa] = res;
        if (nb == 4) begin
          e_rdy_low = 1;
        end else begin
          e_rd      = 1'b1;
          e_win     = 2;
          e_rdy_low = 3;
        end
      end else begin
        v = 0;
        for (int b = 0; b < nb; b++) v += longint'(word[8*(lane+b) +: 8]) << (8*b);
        if (!uns && nb < 4 && v >= (longint'(1) << (8*nb-1))) v -= longint'(1) << (8*nb);
        e_rdata   = v[31:0];
        e_rd      = 1'b1;
        e_win     = 2;
        e_rdy_low = 2;
      end
    end
  endtask

  // Issues one request from an idle DUT, observes six cycles and checks against the model.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [13:0] addr, input logic [31:0] wdata);
    predict(we, size, uns, addr, wdata);
    g_resp = 0; g_rd = 0; g_wr = 0; g_rdy_low = 0; g_win = -1;
    g_rdata = 32'h0; g_err = 1'b0; g_waddr = '0; g_wdata = 32'h0; g_raddr = '0;
    checkOutput("ready_before_req", 32'(req_ready), 32'h1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int w = 0; w < 6; w++) begin
      @(posedge clk); #1;
      if (w == 0) req_valid = 1'b0;
      if (resp_valid) begin
        g_resp++;
        g_win   = w;
        g_rdata = resp_rdata;
        g_err   = resp_err;
      end
      if (rd_en) begin
        g_rd++;
        g_raddr = rd_addr;
      end
      if (wr_en) begin
        g_wr++;
        g_waddr = wr_addr;
        g_wdata = wr_data;
      end
      if (!req_ready) g_rdy_low++;
    end
    checkOutput("resp_pulse_count", 32'(g_resp), 32'h1);
    checkOutput("resp_cycle", 32'(g_win), 32'(e_win));
    checkOutput("resp_err", 32'(g_err), 32'(e_err));
    checkOutput("resp_rdata", g_rdata, e_rdata);
    checkOutput("rd_en_pulses", 32'(g_rd), 32'(e_rd));
    checkOutput("wr_en_pulses", 32'(g_wr), 32'(e_wr));
    checkOutput("ready_low_cycles", 32'(g_rdy_low), 32'(e_rdy_low));
    if (e_rd) checkOutput("rd_addr", 32'(g_raddr), 32'(e_waddr));
    if (e_wr) begin
      checkOutput("wr_addr", 32'(g_waddr), 32'(e_waddr));
      checkOutput("wr_data", g_wdata, e_wdata);
      checkOutput("ram_word", ram[e_waddr], shadow[e_waddr]);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          rd_q[$];
    int          rsp_q[$];
    int          wr_seen;
    logic [1:0]  rsize;
    int          r;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 14'h010, 32'h80FF7F01, 32'h0,        1'b0, 32'h80FF7F01};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 14'h013, 32'h0,        32'hFFFFFF80, 1'b0, 32'h80FF7F01};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 14'h013, 32'h0,        32'h00000080, 1'b0, 32'h80FF7F01};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 14'h012, 32'h0,        32'hFFFF80FF, 1'b0, 32'h80FF7F01};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 14'h010, 32'h0,        32'h00007F01, 1'b0, 32'h80FF7F01};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 14'h010, 32'h11223344, 32'h0,        1'b0, 32'h11223344};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 14'h011, 32'hFFFFFFAA, 32'h0,        1'b0, 32'h1122AA44};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        32'h1122AA44, 1'b0, 32'h1122AA44};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[10] = '{1'b0, 2'd1, 1'b0, 14'h011, 32'h0,        32'h0,        1'b1, 32'h1122AA44};
`else
    tbl[10] = '{1'b0, 2'd1, 1'b0, 14'h011, 32'h0,        32'hFFFFAA44, 1'b0, 32'h1122AA44};
`endif
    tbl[11] = '{1'b0, 2'd3, 1'b0, 14'h010, 32'h0,        32'h0,        1'b1, 32'h1122AA44};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 14'h012, 32'h0000BEEF, 32'h0,        1'b0, 32'hBEEFAA44};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[13] = '{1'b1, 2'd2, 1'b0, 14'h013, 32'hCAFEF00D, 32'h0,        1'b1, 32'hBEEFAA44};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 14'h012, 32'h0,        32'hFFFFFFEF, 1'b0, 32'hBEEFAA44};
`else
    tbl[13] = '{1'b1, 2'd2, 1'b0, 14'h013, 32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 14'h012, 32'h0,        32'hFFFFFFFE, 1'b0, 32'hCAFEF00D};
`endif

    for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset_rd_en", 32'(rd_en), 32'h0);
    checkOutput("reset_wr_en", 32'(wr_en), 32'h0);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'h0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset_rd_addr", 32'(rd_addr), 32'h0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("reset_wr_data", wr_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
      checkOutput($sformatf("tbl%0d_rdata", i), g_rdata, tbl[i].exp_rdata);
      checkOutput($sformatf("tbl%0d_err", i), 32'(g_err), 32'(tbl[i].exp_err));
      checkOutput($sformatf("tbl%0d_mem", i), ram[tbl[i].addr[13:2]], tbl[i].exp_mem);
    end

    // Reset while a byte store sits in WAIT: the write must never happen.
    applyStimulus(1'b1, 2'd2, 1'b0, 14'h020, 32'h11223344);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 14'h021; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready_immediate", 32'(req_ready), 32'h1);
    checkOutput("midrst_rd_en_immediate", 32'(rd_en), 32'h0);
    wr_seen = 0;
    for (int w = 0; w < 3; w++) begin
      @(posedge clk); #1;
      if (wr_en) wr_seen++;
    end
    rst = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(posedge clk); #1;
      if (wr_en) wr_seen++;
    end
    checkOutput("midrst_no_write", 32'(wr_seen), 32'h0);
    checkOutput("midrst_ram_unchanged", ram[8], 32'h11223344);
    checkOutput("midrst_ready_after", 32'(req_ready), 32'h1);

    // Held request: three loads accepted every third cycle.
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 14'h010; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int w = 0; w < 9; w++) begin
      @(posedge clk); #1;
      if (w == 6) req_valid = 1'b0;
      if (rd_en) rd_q.push_back(w);
      if (resp_valid) begin
        rsp_q.push_back(w);
        checkOutput("held_rdata", resp_rdata, shadow[4]);
      end
    end
    checkOutput("held_accept_count", 32'(rd_q.size()), 32'h3);
    checkOutput("held_resp_count", 32'(rsp_q.size()), 32'h3);
    foreach (rd_q[k]) checkOutput($sformatf("held_accept%0d_cycle", k), 32'(rd_q[k]), 32'(3*k));
    foreach (rsp_q[k]) checkOutput($sformatf("held_resp%0d_cycle", k), 32'(rsp_q[k]), 32'(3*k+2));
    @(posedge clk); #1;

    for (int w = 0; w < 8; w++) applyStimulus(1'b1, 2'd2, 1'b0, 14'(w*4), $urandom);
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      rsize = (r == 9) ? 2'd3 : 2'(r % 3);
      applyStimulus(1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)),
                    14'($urandom_range(0, 31)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
